// File: rtl/hc_sb.sv
// hc_sb: hazard controller for the F/D/E/M/W core with an MDU scoreboard,
// load-use stalls, E-stage M/W forwarding and a deferred-jump latch.
//
// Parameters: AW (reg addr width), MAX_OUT (in-flight MDU op limit),
//   CW (outstanding count width, 2**CW > MAX_OUT), PCW (perf counter width).
// Inputs:  clk, rst_n (async active-low), je, busy_M,
//   rs1/rs2_addr_D, rs1/rs2_use_D, rd_D, wen_D, long_D,
//   rs1/rs2_addr_E, rd_E/M/W, wen_E/M/W, load_E, long_E, long_done, long_rd.
// Outputs: stall_F/D/E/M/W, flush_D/E/M/W, fwd1_sel, fwd2_sel
//   (00 regfile, 01 M, 10 W), outstanding.
// Optional macro HC_PERF_CNT_EN adds perf_stall_cyc and perf_flush_cnt,
//   saturating counters of stall_D and flush_D cycles.
module hc_sb #(
    parameter int AW      = 5,
    parameter int MAX_OUT = 4,
    parameter int CW      = 3,
    parameter int PCW     = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          je,
    input  logic          busy_M,
    input  logic [AW-1:0] rs1_addr_D,
    input  logic [AW-1:0] rs2_addr_D,
    input  logic          rs1_use_D,
    input  logic          rs2_use_D,
    input  logic [AW-1:0] rd_D,
    input  logic          wen_D,
    input  logic          long_D,
    input  logic [AW-1:0] rs1_addr_E,
    input  logic [AW-1:0] rs2_addr_E,
    input  logic [AW-1:0] rd_E,
    input  logic [AW-1:0] rd_M,
    input  logic [AW-1:0] rd_W,
    input  logic          wen_E,
    input  logic          wen_M,
    input  logic          wen_W,
    input  logic          load_E,
    input  logic          long_E,
    input  logic          long_done,
    input  logic [AW-1:0] long_rd,
    output logic          stall_F,
    output logic          stall_D,
    output logic          flush_D,
    output logic          stall_E,
    output logic          flush_E,
    output logic          stall_M,
    output logic          flush_M,
    output logic          stall_W,
    output logic          flush_W,
    output logic [1:0]    fwd1_sel,
    output logic [1:0]    fwd2_sel,
`ifdef HC_PERF_CNT_EN
    output logic [PCW-1:0] perf_stall_cyc,
    output logic [PCW-1:0] perf_flush_cnt,
`endif
    output logic [CW-1:0] outstanding
);

    localparam int NR = 2**AW;

    logic [NR-1:0] sb, sb_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          jpend;
    logic          jflush;
    logic          load_use;
    logic          sb_raw;
    logic          sb_waw;
    logic          cap;
    logic          hazard;
    logic          issue;

    assign jflush = je | jpend;

    assign load_use = load_E & wen_E & (rd_E != '0) &
                      ((rs1_use_D & (rs1_addr_D == rd_E)) |
                       (rs2_use_D & (rs2_addr_D == rd_E)));

    assign sb_raw = (rs1_use_D & sb[rs1_addr_D]) |
                    (rs2_use_D & sb[rs2_addr_D]);
    assign sb_waw = wen_D & sb[rd_D];

    // A completion in the same cycle frees a slot for the new op.
    assign cap = long_D & (cnt == CW'(MAX_OUT)) & ~long_done;

    assign hazard = load_use | sb_raw | sb_waw | cap;

    always_comb begin
        stall_F = 1'b0;
        stall_D = 1'b0;
        flush_D = 1'b0;
        stall_E = 1'b0;
        flush_E = 1'b0;
        stall_M = 1'b0;
        flush_M = 1'b0;
        stall_W = 1'b0;
        flush_W = 1'b0;
        priority case (1'b1)
            busy_M: begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                stall_E = 1'b1;
                stall_M = 1'b1;
                flush_W = 1'b1;
            end
            jflush: begin
                flush_D = 1'b1;
                flush_E = 1'b1;
            end
            hazard: begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                flush_E = 1'b1;
            end
            default: ;
        endcase
    end

    // M result is younger than W, so it wins.
    always_comb begin
        fwd1_sel = 2'b00;
        fwd2_sel = 2'b00;
        if (wen_M && rd_M != '0 && rd_M == rs1_addr_E)
            fwd1_sel = 2'b01;
        else if (wen_W && rd_W != '0 && rd_W == rs1_addr_E)
            fwd1_sel = 2'b10;
        if (wen_M && rd_M != '0 && rd_M == rs2_addr_E)
            fwd2_sel = 2'b01;
        else if (wen_W && rd_W != '0 && rd_W == rs2_addr_E)
            fwd2_sel = 2'b10;
    end

    assign issue = long_E & ~stall_E & ~flush_E & (rd_E != '0);

    // Set is applied after clear so a same-register reissue wins.
    always_comb begin
        sb_n = sb;
        if (long_done)
            sb_n[long_rd] = 1'b0;
        if (issue)
            sb_n[rd_E] = 1'b1;
        sb_n[0] = 1'b0;
    end

    always_comb begin
        cnt_n = cnt;
        if (issue && !long_done)
            cnt_n = cnt + CW'(1);
        else if (!issue && long_done && cnt != '0)
            cnt_n = cnt - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb    <= '0;
            cnt   <= '0;
            jpend <= 1'b0;
        end else begin
            sb    <= sb_n;
            cnt   <= cnt_n;
            // Hold a jump seen during an LSU stall until the pipe moves.
            jpend <= busy_M & (jpend | je);
        end
    end

    assign outstanding = cnt;

`ifdef HC_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cyc <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall_D && !(&perf_stall_cyc))
                perf_stall_cyc <= perf_stall_cyc + PCW'(1);
            if (flush_D && !(&perf_flush_cnt))
                perf_flush_cnt <= perf_flush_cnt + PCW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hc_sb.sv
// tb_hc_sb: self-checking bench for hc_sb (default build).
// Expected outputs are queued when stimulus is driven and compared at negedge.
module tb_hc_sb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       je, busy_M;
    logic [4:0] rs1_addr_D, rs2_addr_D, rd_D;
    logic       rs1_use_D, rs2_use_D, wen_D, long_D;
    logic [4:0] rs1_addr_E, rs2_addr_E, rd_E, rd_M, rd_W, long_rd;
    logic       wen_E, wen_M, wen_W, load_E, long_E, long_done;
    logic       stall_F, stall_D, flush_D, stall_E, flush_E;
    logic       stall_M, flush_M, stall_W, flush_W;
    logic [1:0] fwd1_sel, fwd2_sel;
    logic [2:0] outstanding;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       sf, sd, fd, se, fe, sm, fm, sw, fw;
        logic [1:0] f1, f2;
        logic [2:0] o;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    hc_sb dut (
        .clk(clk), .rst_n(rst_n), .je(je), .busy_M(busy_M),
        .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D),
        .rs1_use_D(rs1_use_D), .rs2_use_D(rs2_use_D),
        .rd_D(rd_D), .wen_D(wen_D), .long_D(long_D),
        .rs1_addr_E(rs1_addr_E), .rs2_addr_E(rs2_addr_E),
        .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W),
        .wen_E(wen_E), .wen_M(wen_M), .wen_W(wen_W),
        .load_E(load_E), .long_E(long_E),
        .long_done(long_done), .long_rd(long_rd),
        .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D),
        .stall_E(stall_E), .flush_E(flush_E),
        .stall_M(stall_M), .flush_M(flush_M),
        .stall_W(stall_W), .flush_W(flush_W),
        .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
        .outstanding(outstanding)
    );

    function automatic exp_t sample();
        exp_t r;
        r.sf = stall_F;  r.sd = stall_D;  r.fd = flush_D;
        r.se = stall_E;  r.fe = flush_E;  r.sm = stall_M;
        r.fm = flush_M;  r.sw = stall_W;  r.fw = flush_W;
        r.f1 = fwd1_sel; r.f2 = fwd2_sel; r.o  = outstanding;
        return r;
    endfunction

    // Reference model of the priority: busy, then jump, then hazard.
    function automatic exp_t ex(bit hz, bit fj, bit bz,
                                logic [1:0] f1, logic [1:0] f2,
                                logic [2:0] o);
        exp_t r = '0;
        r.f1 = f1; r.f2 = f2; r.o = o;
        if (bz) begin
            r.sf = 1; r.sd = 1; r.se = 1; r.sm = 1; r.fw = 1;
        end else if (fj) begin
            r.fd = 1; r.fe = 1;
        end else if (hz) begin
            r.sf = 1; r.sd = 1; r.fe = 1;
        end
        return r;
    endfunction

    task automatic idle();
        je = 0; busy_M = 0;
        rs1_addr_D = 0; rs2_addr_D = 0; rd_D = 0;
        rs1_use_D = 0; rs2_use_D = 0; wen_D = 0; long_D = 0;
        rs1_addr_E = 0; rs2_addr_E = 0;
        rd_E = 0; rd_M = 0; rd_W = 0; long_rd = 0;
        wen_E = 0; wen_M = 0; wen_W = 0;
        load_E = 0; long_E = 0; long_done = 0;
    endtask

    task automatic test_reset();
        exp_t e, o;
        rst_n = 0;
        idle();
        q.push_back(ex(0, 0, 0, 2'b00, 2'b00, 3'd0));
        @(negedge clk);
        e = q.pop_front(); o = sample(); checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL reset_low got %h want %h", o, e);
        end
        #2 rst_n = 1;
        @(posedge clk); #1;
        q.push_back(ex(0, 0, 0, 2'b00, 2'b00, 3'd0));
        @(negedge clk);
        e = q.pop_front(); o = sample(); checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL reset_idle got %h want %h", o, e);
        end
    endtask

    task automatic test_load_use();
        exp_t e, o;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            idle();
            case (i)
                0: begin
                    load_E = 1; wen_E = 1; rd_E = 5;
                    rs1_use_D = 1; rs1_addr_D = 5;
                    q.push_back(ex(1, 0, 0, 2'b00, 2'b00, 3'd0));
                end
                1: begin
                    wen_M = 1; rd_M = 5; rs1_addr_E = 5;
                    q.push_back(ex(0, 0, 0, 2'b01, 2'b00, 3'd0));
                end
                2: begin
                    load_E = 1; wen_E = 1; rd_E = 5;
                    rs2_addr_D = 5;
                    q.push_back(ex(0, 0, 0, 2'b00, 2'b00, 3'd0));
                end
                3: begin
                    load_E = 1; wen_E = 1; rd_E = 0;
                    rs1_use_D = 1; rs1_addr_D = 0;
                    q.push_back(ex(0, 0, 0, 2'b00, 2'b00, 3'd0));
                end
                4: begin
                    wen_E = 1; rd_E = 5;
                    rs2_use_D = 1; rs2_addr_D = 5;
                    q.push_back(ex(0, 0, 0, 2'b00, 2'b00, 3'd0));
                end
                default: begin
                    load_E = 1; wen_E = 1; rd_E = 6;
                    rs2_use_D = 1; rs2_addr_D = 6;
                    q.push_back(ex(1, 0, 0, 2'b00, 2'b00, 3'd0));
                end
            endcase
            @(negedge clk);
            e = q.pop_front(); o = sample(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL load_use[%0d] got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_forward();
        exp_t e, o;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            idle();
            case (i)
                0: begin
                    wen_M = 1; wen_W = 1; rd_M = 7; rd_W = 7;
                    rs2_addr_E = 7;
                    q.push_back(ex(0, 0, 0, 2'b00, 2'b01, 3'd0));
                end
                1: begin
                    wen_M = 1; wen_W = 1; rd_M = 0; rd_W = 7;
                    rs2_addr_E = 7;
                    q.push_back(ex(0, 0, 0, 2'b00, 2'b10, 3'd0));
                end
                2: begin
                    wen_W = 1; rd_M = 7; rd_W = 7; rs2_addr_E = 7;
                    q.push_back(ex(0, 0, 0, 2'b00, 2'b10, 3'd0));
                end
                3: begin
                    rd_M = 7; rd_W = 7; rs2_addr_E = 7;
                    q.push_back(ex(0, 0, 0, 2'b00, 2'b00, 3'd0));
                end
                4: begin
                    wen_M = 1; wen_W = 1;
                    q.push_back(ex(0, 0, 0, 2'b00, 2'b00, 3'd0));
                end
                default: begin
                    wen_W = 1; rd_W = 3; rs1_addr_E = 3;
                    wen_M = 1; rd_M = 4; rs2_addr_E = 4;
                    q.push_back(ex(0, 0, 0, 2'b10, 2'b01, 3'd0));
                end
            endcase
            @(negedge clk);
            e = q.pop_front(); o = sample(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL forward[%0d] got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_scoreboard();
        exp_t e, o;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            idle();
            case (i)
                0: begin
                    long_E = 1; wen_E = 1; rd_E = 9;
                    q.push_back(ex(0, 0, 0, 2'b00, 2'b00, 3'd0));
                end
                1: begin
                    rs1_use_D = 1; rs1_addr_D = 9;
                    q.push_back(ex(1, 0, 0, 2'b00, 2'b00, 3'd1));
                end
                2: begin
                    wen_D = 1; rd_D = 9;
                    q.push_back(ex(1, 0, 0, 2'b00, 2'b00, 3'd1));
                end
                3: begin
                    rs2_use_D = 1; rs2_addr_D = 9;
                    long_done = 1; long_rd = 9;
                    q.push_back(ex(1, 0, 0, 2'b00, 2'b00, 3'd1));
                end
                default: begin
                    rs2_use_D = 1; rs2_addr_D = 9;
                    q.push_back(ex(0, 0, 0, 2'b00, 2'b00, 3'd0));
                end
            endcase
            @(negedge clk);
            e = q.pop_front(); o = sample(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL scoreboard[%0d] got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_capacity();
        exp_t e, o;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            idle();
            if (i < 4) begin
                long_E = 1; wen_E = 1; rd_E = 5'(i + 1);
                q.push_back(ex(0, 0, 0, 2'b00, 2'b00, 3'(i)));
            end else begin
                case (i)
                    4: begin
                        long_D = 1;
                        q.push_back(ex(1, 0, 0, 2'b00, 2'b00, 3'd4));
                    end
                    5: begin
                        long_D = 1; long_done = 1; long_rd = 1;
                        q.push_back(ex(0, 0, 0, 2'b00, 2'b00, 3'd4));
                    end
                    6: begin
                        long_E = 1; wen_E = 1; rd_E = 0;
                        q.push_back(ex(0, 0, 0, 2'b00, 2'b00, 3'd3));
                    end
                    7: begin
                        je = 1; long_E = 1; wen_E = 1; rd_E = 6;
                        q.push_back(ex(0, 1, 0, 2'b00, 2'b00, 3'd3));
                    end
                    8: begin
                        long_done = 1; long_rd = 2;
                        q.push_back(ex(0, 0, 0, 2'b00, 2'b00, 3'd3));
                    end
                    9: begin
                        long_done = 1; long_rd = 3;
                        q.push_back(ex(0, 0, 0, 2'b00, 2'b00, 3'd2));
                    end
                    10: begin
                        long_done = 1; long_rd = 4;
                        q.push_back(ex(0, 0, 0, 2'b00, 2'b00, 3'd1));
                    end
                    default: begin
                        rs1_use_D = 1; rs1_addr_D = 6;
                        q.push_back(ex(0, 0, 0, 2'b00, 2'b00, 3'd0));
                    end
                endcase
            end
            @(negedge clk);
            e = q.pop_front(); o = sample(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL capacity[%0d] got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_deferred_jump();
        exp_t e, o;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            idle();
            case (i)
                0, 1, 2: begin
                    busy_M = 1; je = 1;
                    if (i == 1) begin
                        load_E = 1; wen_E = 1; rd_E = 5;
                        rs1_use_D = 1; rs1_addr_D = 5;
                    end
                    q.push_back(ex(0, 0, 1, 2'b00, 2'b00, 3'd0));
                end
                3: q.push_back(ex(0, 1, 0, 2'b00, 2'b00, 3'd0));
                4: q.push_back(ex(0, 0, 0, 2'b00, 2'b00, 3'd0));
                default: begin
                    je = 1;
                    load_E = 1; wen_E = 1; rd_E = 5;
                    rs1_use_D = 1; rs1_addr_D = 5;
                    q.push_back(ex(1, 1, 0, 2'b00, 2'b00, 3'd0));
                end
            endcase
            @(negedge clk);
            e = q.pop_front(); o = sample(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL jump[%0d] got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e, o;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            idle();
            case (i)
                0: begin
                    long_E = 1; wen_E = 1; rd_E = 3;
                    q.push_back(ex(0, 0, 0, 2'b00, 2'b00, 3'd0));
                end
                1: begin
                    long_E = 1; wen_E = 1; rd_E = 8;
                    q.push_back(ex(0, 0, 0, 2'b00, 2'b00, 3'd1));
                end
                2: begin
                    busy_M = 1; je = 1;
                    q.push_back(ex(0, 0, 1, 2'b00, 2'b00, 3'd2));
                end
                default: begin
                    rs1_use_D = 1; rs1_addr_D = 3;
                    q.push_back(ex(0, 1, 0, 2'b00, 2'b00, 3'd2));
                end
            endcase
            @(negedge clk);
            e = q.pop_front(); o = sample(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL arst_pre[%0d] got %h want %h", i, o, e);
            end
        end
        #1 rst_n = 0;
        q.push_back(ex(0, 0, 0, 2'b00, 2'b00, 3'd0));
        #1;
        e = q.pop_front(); o = sample(); checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL arst_now got %h want %h", o, e);
        end
        @(posedge clk); #1;
        rst_n = 1;
        long_done = 1; long_rd = 3;
        q.push_back(ex(0, 0, 0, 2'b00, 2'b00, 3'd0));
        @(negedge clk);
        e = q.pop_front(); o = sample(); checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL arst_done got %h want %h", o, e);
        end
        @(posedge clk); #1;
        idle();
        q.push_back(ex(0, 0, 0, 2'b00, 2'b00, 3'd0));
        @(negedge clk);
        e = q.pop_front(); o = sample(); checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL arst_after got %h want %h", o, e);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forward();
        test_scoreboard();
        test_capacity();
        test_deferred_jump();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hc_sb.md
Name: hc_sb

Overview:
- Second-generation hazard controller for the 5-stage core (F/D/E/M/W).
- Keeps the existing priority order: LSU busy stall, then taken-jump flush, then RAW stall.
- Adds a per-register scoreboard for a variable-latency multi-cycle unit (MDU), with an outstanding-op limit.
- Adds load-use-only RAW stalling backed by E-stage M/W forwarding selects, a deferred-jump latch, and use-enable qualification of operands and writes.

Parameters:
AW, 5, register address width; register file has 2**AW entries, x0 hardwired zero
MAX_OUT, 4, maximum outstanding MDU ops (1..2**AW-1)
CW, 3, outstanding-count width, must satisfy 2**CW > MAX_OUT
PCW, 32, perf counter width (only with HC_PERF_CNT_EN)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
je  in  1  jump/branch taken by instruction in E
busy_M  in  1  LSU busy, whole pipeline must hold
rs1_addr_D, rs2_addr_D  in  AW  source registers of instruction in D
rs1_use_D, rs2_use_D  in  1  D instruction actually reads rs1/rs2
rd_D  in  AW  destination of D instruction
wen_D  in  1  D instruction writes rd_D
long_D  in  1  D instruction is an MDU op
rs1_addr_E, rs2_addr_E  in  AW  sources of instruction in E
rd_E, rd_M, rd_W  in  AW  destinations in E/M/W
wen_E, wen_M, wen_W  in  1  destination write enables per stage
load_E  in  1  instruction in E is a load
long_E  in  1  instruction in E issues to MDU this cycle
long_done  in  1  MDU writes back result this cycle
long_rd  in  AW  destination of completing MDU op
stall_F, stall_D, flush_D, stall_E, flush_E, stall_M, flush_M, stall_W, flush_W  out  1  pipeline register controls
fwd1_sel, fwd2_sel  out  2  E-operand source: 00 regfile, 01 M result, 10 W result
outstanding  out  CW  current count of in-flight MDU ops

Behaviour:
State:
- sb[2**AW-1:0] busy bits; sb[0] never set.
- cnt[CW-1:0] outstanding counter.
- jpend, one bit.
- Async clear of all state on rst_n low.
- Outputs are combinational from state and inputs; with zero state and idle inputs every stall/flush output is 0 and fwd selects are 00.
- jflush = je | jpend.

Priority, evaluated in order:
1. busy_M
   - stall_F, stall_D, stall_E, stall_M = 1; flush_W = 1.
   - If je, set jpend.
   - No flush_D/flush_E this cycle.
2. else jflush
   - flush_D = flush_E = 1; jpend cleared next edge.
   - RAW and scoreboard checks ignored.
3. else hazard: stall_F = stall_D = 1, flush_E = 1 when any of:
   - Load-use: load_E & wen_E & rd_E != 0 & ((rs1_use_D & rs1_addr_D == rd_E) | (rs2_use_D & rs2_addr_D == rd_E)).
   - Scoreboard RAW: rsN_use_D & sb[rsN_addr_D].
   - Scoreboard WAW: wen_D & sb[rd_D].
   - Capacity: long_D & cnt == MAX_OUT & !long_done.
   - Non-load RAW against E/M/W is NOT a stall; it is resolved by forwarding.

Forwarding (for E operand N):
- 01 if wen_M & rd_M != 0 & rd_M == rsN_addr_E.
- else 10 if wen_W & rd_W != 0 & rd_W == rsN_addr_E.
- else 00. M has priority over W.
- Register file is write-before-read, so no D-stage forward from W is needed.

Scoreboard update at each rising clk:
- issue = long_E & !stall_E & !flush_E & rd_E != 0.
- issue sets sb[rd_E].
- long_done clears sb[long_rd].
- Same register set and clear in one cycle: set wins.
- cnt += issue, cnt -= long_done (only when cnt > 0; no underflow). Issue and done together leave cnt unchanged.
- An issue with rd_E == 0 is not counted.
- A long_done for an already-clear bit (e.g. after mid-op reset) is ignored apart from the saturating decrement.

Reset mid-operation:
- All scoreboard bits, cnt and jpend clear immediately.
- In-flight MDU completions are then harmless per the rule above.

Optional Feature:
HC_PERF_CNT_EN
- Defined: adds outputs perf_stall_cyc[PCW-1:0] and perf_flush_cnt[PCW-1:0].
  - perf_stall_cyc increments each cycle stall_D=1.
  - perf_flush_cnt increments each cycle flush_D=1.
  - Both saturate at all-ones and reset to 0 on rst_n low.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Load-use: load_E=1, wen_E=1, rd_E=5; D with rs1_use_D=1, rs1_addr_D=5 -> one cycle stall_F=stall_D=flush_E=1. Next cycle, with the load in M, rs1_addr_E=5 -> fwd1_sel=01.
- Forward priority: rd_M=rd_W=7, both wen=1, rs2_addr_E=7 -> fwd2_sel=01. With rd_M=0 -> fwd2_sel=10.
- Scoreboard: issue MDU to x9 -> sb[9]=1, outstanding=1. D reads x9 -> stall until long_done with long_rd=9, then released the following cycle with outstanding=0.
- Capacity, MAX_OUT=4: four issues to x1..x4 -> outstanding=4; long_D=1 stalls. Asserting long_done same cycle -> no stall.
- Deferred jump: je=1 with busy_M=1 for 3 cycles -> full stall, flush_W=1, no flush_D. First cycle busy_M=0 -> flush_D=flush_E=1 even if je already dropped.
- Async reset: rst_n low with sb[3]=1, outstanding=2, jpend=1 -> all cleared immediately. Subsequent long_done with long_rd=3 -> outstanding stays 0.
